qam_symbol_serializer: RTL and testbench
========================================

# qam_symbol_serializer

Read side of the symbol FIFO in the QAM demapper datapath. Pops 4-bit demapped symbols from the dual-clock symbol FIFO (normal mode, one-cycle read latency) in the `dclk` domain and shifts them out MSB-first as a bit stream with a valid/ready handshake. Marks frame boundaries and counts mid-frame underruns.

## Interface
Parameters:
- `DATA_W`, 4, bits per symbol (QAM16); must match FIFO width
- `FRAME_SYMS`, 16, symbols per frame; ≥ 2
- `CNT_W`, 16, width of the underrun counter

Ports:
- `dclk`  in  1  read-domain clock; all state on rising edge
- `aclr`  in  1  reset, asynchronous, active-high
- `rdempty`  in  1  FIFO empty flag (`dclk` domain)
- `q`  in  DATA_W  FIFO read data, valid the cycle after `rdreq`
- `rdreq`  out  1  FIFO pop request (combinational)
- `bit_out`  out  1  serial bit, MSB of current symbol first
- `bit_valid`  out  1  `bit_out` valid
- `bit_ready`  in  1  consumer accepts `bit_out` when `bit_valid & bit_ready`
- `frame_start`  out  1  high with first bit of symbol 0 of a frame
- `underrun_cnt`  out  CNT_W  saturating count of mid-frame FIFO starvation events

## Operation
- States: IDLE, LOAD, SHIFT.
- IDLE: `bit_valid`=0. `rdreq` = !`rdempty`; when asserted, next state LOAD.
- LOAD: `bit_valid`=0, `rdreq`=0. Capture `q` into shift register, `bit_cnt`←0, next state SHIFT.
- SHIFT: `bit_valid`=1, `bit_out` = shift register MSB. On handshake: shift left one, `bit_cnt`++.
- Last bit (`bit_cnt`=DATA_W-1) accepted: `sym_cnt` advances (wraps FRAME_SYMS-1→0). If !`rdempty`: `rdreq`=1 same cycle, next LOAD. Else next IDLE.
- No handshake in SHIFT: shift register, `bit_cnt`, `bit_out` held stable; `bit_valid` stays 1.
- `frame_start` = SHIFT & `bit_cnt`=0 & `sym_cnt`=0.
- Underrun: SHIFT→IDLE transition with updated `sym_cnt`≠0 (frame incomplete) increments `underrun_cnt`; saturates at 2^CNT_W-1. One increment per starvation event, not per idle cycle.
- Starvation at frame end (`sym_cnt` wraps to 0) is not an underrun.
- `rdreq` is never asserted while `rdempty`=1.

## Timing
- Reset (async assert, sync deassert by upstream): state IDLE, `rdreq`=0, `bit_out`=0, `bit_valid`=0, `frame_start`=0, `underrun_cnt`=0, `sym_cnt`=0, `bit_cnt`=0, shift register 0.
- `aclr` mid-symbol: partial symbol discarded; first symbol after reset is frame symbol 0.
- Latency: `rdreq` at edge N → LOAD in cycle N+1 → first bit valid cycle N+2.
- Throughput with `bit_ready`=1 and FIFO non-empty: DATA_W bits per DATA_W+1 cycles (one LOAD bubble per symbol).
- `rdempty` deasserting while in IDLE: `rdreq` in that same cycle.
- `bit_ready` may toggle freely; block never drops or duplicates bits.

## Structure
- Shared package `qam_demap_pkg`: `DATA_W` default (4), state encoding constants (IDLE/LOAD/SHIFT), `FRAME_SYMS` default.
- Single module; no sub-module. Saturating counter inline.

## Test plan
- Reset, FIFO empty: all outputs 0; `rdreq` never asserted over 20 cycles.
- Write 4'hA, 4'h3 to FIFO, `bit_ready`=1: bit stream 1,0,1,0,0,0,1,1; one-cycle gap between symbols; `frame_start` on first bit only.
- FRAME_SYMS=16, 17 symbols 0..16 streamed: `frame_start` on first bit of symbol 0 and symbol 16; `underrun_cnt`=0 after FIFO drains at frame boundary... then underrun_cnt=1 because 17th symbol leaves frame incomplete.
- `bit_ready` toggled every other cycle with symbol 4'hC: bits 1,1,0,0 each held stable until accepted; no `rdreq` before last bit accepted.
- FIFO starved after 5 symbols of a frame, then refilled: `underrun_cnt`=1; stream resumes with `sym_cnt`=5, no `frame_start`.
- `aclr` pulsed during bit 2 of symbol 4'h9: outputs 0 immediately; next symbol 4'h6 out as 0,1,1,0 with `frame_start`=1.

Source files
------------

// File: rtl/qam_demap_pkg.sv
// Shared definitions for the QAM demapper datapath: default symbol geometry
// and the serializer state encoding.
package qam_demap_pkg;

  localparam int unsigned DATA_W_DEF     = 4;
  localparam int unsigned FRAME_SYMS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/qam_symbol_serializer.sv
// Pops demapped symbols from the dual-clock symbol FIFO and shifts them out
// MSB-first over a valid/ready bit stream, marking frames and counting underruns.
module qam_symbol_serializer
  import qam_demap_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FRAME_SYMS = FRAME_SYMS_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              dclk,
  input  logic              aclr,
  input  logic              rdempty,
  input  logic [DATA_W-1:0] q,
  output logic              rdreq,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              frame_start,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int unsigned BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SCW = $clog2(FRAME_SYMS);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg;
  logic [BCW-1:0]    bit_cnt;
  logic [SCW-1:0]    sym_cnt, sym_nxt;
  logic              handshake, last_bit, last_acc;

  assign handshake = (state == SHIFT) && bit_ready;
  assign last_bit  = (bit_cnt == BCW'(DATA_W - 1));
  assign last_acc  = handshake && last_bit;
  assign sym_nxt   = (sym_cnt == SCW'(FRAME_SYMS - 1)) ? '0 : sym_cnt + SCW'(1);

  assign bit_out     = sreg[DATA_W-1];
  assign bit_valid   = (state == SHIFT);
  assign frame_start = (state == SHIFT) && (bit_cnt == '0) && (sym_cnt == '0);

  // rdreq is gated by aclr so the FIFO is never popped while held in reset.
  always_comb begin
    state_nxt = state;
    rdreq     = 1'b0;
    case (state)
      IDLE: begin
        if (!rdempty && !aclr) begin
          rdreq     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SHIFT;
      SHIFT: begin
        if (last_acc) begin
          if (!rdempty) begin
            rdreq     = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge aclr) begin
    if (aclr) begin
      state        <= IDLE;
      sreg         <= '0;
      bit_cnt      <= '0;
      sym_cnt      <= '0;
      underrun_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        sreg    <= q;
        bit_cnt <= '0;
      end else if (handshake) begin
        sreg    <= sreg << 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
      end
      // Starving with the frame incomplete is one underrun event.
      if (last_acc) begin
        sym_cnt <= sym_nxt;
        if (rdempty && (sym_nxt != '0) && (underrun_cnt != '1))
          underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_serializer.sv
// Self-checking bench for qam_symbol_serializer: FIFO model, queue-based
// bit-stream reference, directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_qam_symbol_serializer;

  localparam int DW   = 4;
  localparam int FS   = 16;
  localparam int CW   = 3;
  localparam int UMAX = (1 << CW) - 1;

  logic          dclk = 1'b0;
  logic          aclr = 1'b1;
  logic          rdempty = 1'b1;
  logic          bit_ready = 1'b0;
  logic [DW-1:0] q = '0;
  logic          rdreq, bit_out, bit_valid, frame_start;
  logic [CW-1:0] underrun_cnt;

  qam_symbol_serializer #(.DATA_W(DW), .FRAME_SYMS(FS), .CNT_W(CW)) dut (
    .dclk(dclk), .aclr(aclr), .rdempty(rdempty), .q(q), .rdreq(rdreq),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .frame_start(frame_start), .underrun_cnt(underrun_cnt)
  );

  always #5 dclk = ~dclk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model state
  int        fifo[$];
  bit        cur[$];      // bits of the symbol currently being presented
  bit        loading = 0;
  logic [DW-1:0] ld_val = '0;
  int        sym_idx = 0;
  int        und = 0;

  // observation log
  bit        obs_bits[$];
  int        obs_cyc[$];
  int        obs_fs = 0;
  int        cyc = 0;
  bit        rd_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit hs, last, erq, ev, rd_s;
    hs = 0; last = 0; erq = 0;
    @(negedge dclk);
    cyc++;
    if (aclr) begin
      chk("reset_rdreq", int'(rdreq), 0);
      chk("reset_bit_valid", int'(bit_valid), 0);
      chk("reset_frame_start", int'(frame_start), 0);
      chk("reset_bit_out", int'(bit_out), 0);
      chk("reset_underrun", int'(underrun_cnt), 0);
    end else begin
      ev   = cur.size() > 0;
      hs   = ev && bit_ready;
      last = hs && cur.size() == 1;
      erq  = !rdempty && !loading && (cur.size() == 0 || last);
      chk("rdreq", int'(rdreq), int'(erq));
      chk("bit_valid", int'(bit_valid), int'(ev));
      if (ev) chk("bit_out", int'(bit_out), int'(cur[0]));
      chk("frame_start", int'(frame_start), int'(ev && cur.size() == DW && sym_idx == 0));
      chk("underrun_cnt", int'(underrun_cnt), und);
      chk("rdreq_while_empty", int'(rdreq & rdempty), 0);
    end
    if (rdreq) rd_seen = 1;
    if (bit_valid && bit_ready) begin
      obs_bits.push_back(bit_out);
      obs_cyc.push_back(cyc);
      if (frame_start) obs_fs++;
    end
    rd_s = rdreq && !rdempty;
    @(posedge dclk);
    #1;
    if (!aclr) begin
      if (hs) void'(cur.pop_front());
      if (last) begin
        sym_idx = (sym_idx + 1) % FS;
        if (!erq && sym_idx != 0 && und < UMAX) und++;
      end
      if (loading) begin
        for (int i = DW - 1; i >= 0; i--) cur.push_back(ld_val[i]);
        loading = 0;
      end
      if (erq) begin
        loading = 1;
        ld_val  = DW'(fifo[0]);
      end
    end
    if (rd_s && fifo.size() > 0) q = DW'(fifo.pop_front());
    rdempty = (fifo.size() == 0);
  endtask

  task automatic push(input int v);
    fifo.push_back(v);
    rdempty = 1'b0;
  endtask

  task automatic clear_log();
    obs_bits.delete();
    obs_cyc.delete();
    obs_fs = 0;
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    #1;
    chk("async_rdreq", int'(rdreq), 0);
    chk("async_bit_valid", int'(bit_valid), 0);
    chk("async_bit_out", int'(bit_out), 0);
    chk("async_frame_start", int'(frame_start), 0);
    chk("async_underrun", int'(underrun_cnt), 0);
    cur.delete();
    loading = 0;
    sym_idx = 0;
    und     = 0;
    step();
    step();
    aclr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while ((fifo.size() > 0 || cur.size() > 0 || loading) && n < maxc) begin
      step();
      n++;
    end
    chk({name, "_drain_in_time"}, int'(n < maxc), 1);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp2;
    logic [3:0] exp4;
    int n;

    // reset, FIFO empty: nothing requested
    do_reset();
    clear_log();
    rd_seen = 0;
    repeat (20) step();
    chk("idle_no_rdreq", int'(rd_seen), 0);
    chk("idle_no_bits", obs_bits.size(), 0);

    // 4'hA then 4'h3 back to back
    bit_ready = 1'b1;
    clear_log();
    push(4'hA);
    push(4'h3);
    wait_idle("ab", 50);
    exp2 = 8'b1010_0011;
    chk("ab_bit_count", obs_bits.size(), 8);
    if (obs_bits.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("ab_bit", int'(obs_bits[i]), int'(exp2[7-i]));
      chk("ab_first_sym_contiguous", obs_cyc[3] - obs_cyc[0], 3);
      chk("ab_one_cycle_gap", obs_cyc[4] - obs_cyc[3], 2);
    end
    chk("ab_frame_start_count", obs_fs, 1);

    // 17 symbols: second frame starts at symbol 16, left incomplete
    do_reset();
    clear_log();
    for (int i = 0; i < 17; i++) push(i % 16);
    wait_idle("frame17", 300);
    chk("frame17_bit_count", obs_bits.size(), 17 * DW);
    chk("frame17_frame_starts", obs_fs, 2);
    chk("frame17_underrun", int'(underrun_cnt), 1);

    // bit_ready toggling with 4'hC
    do_reset();
    clear_log();
    bit_ready = 1'b0;
    push(4'hC);
    n = 0;
    while ((fifo.size() > 0 || cur.size() > 0 || loading) && n < 40) begin
      step();
      bit_ready = ~bit_ready;
      n++;
    end
    chk("toggle_in_time", int'(n < 40), 1);
    exp4 = 4'hC;
    chk("toggle_bit_count", obs_bits.size(), 4);
    if (obs_bits.size() == 4)
      for (int i = 0; i < 4; i++) chk("toggle_bit", int'(obs_bits[i]), int'(exp4[3-i]));
    bit_ready = 1'b1;

    // starvation after 5 symbols, then refill mid-frame
    do_reset();
    clear_log();
    for (int i = 0; i < 5; i++) push(int'($urandom_range(0, 15)));
    wait_idle("starve_a", 100);
    chk("starve_underrun", int'(underrun_cnt), 1);
    repeat (3) step();
    for (int i = 0; i < 3; i++) push(int'($urandom_range(0, 15)));
    wait_idle("starve_b", 100);
    chk("starve_frame_starts", obs_fs, 1);
    chk("starve_underrun_after", int'(underrun_cnt), 2);

    // aclr while bit 2 of 4'h9 is presented
    do_reset();
    clear_log();
    push(4'h9);
    n = 0;
    while (obs_bits.size() < 2 && n < 20) begin
      step();
      n++;
    end
    chk("aclr_reached_bit2", obs_bits.size(), 2);
    do_reset();
    clear_log();
    push(4'h6);
    wait_idle("after_aclr", 50);
    exp4 = 4'h6;
    chk("after_aclr_bit_count", obs_bits.size(), 4);
    if (obs_bits.size() == 4)
      for (int i = 0; i < 4; i++) chk("after_aclr_bit", int'(obs_bits[i]), int'(exp4[3-i]));
    chk("after_aclr_frame_start", obs_fs, 1);

    // repeated single-symbol starvation drives the counter into saturation
    do_reset();
    for (int k = 0; k < 9; k++) begin
      push(int'($urandom_range(0, 15)));
      wait_idle("sat", 50);
    end
    chk("underrun_saturated", int'(underrun_cnt), UMAX);

    // randomized traffic with bursty supply and random back-pressure
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int rate;
      rate = ((c / 250) % 2 == 0) ? 60 : 8;
      if ($urandom_range(0, 99) < rate && fifo.size() < 6) push(int'($urandom_range(0, 15)));
      bit_ready = ($urandom_range(0, 3) != 0);
      step();
      if (c == 1500) do_reset();
    end
    bit_ready = 1'b1;
    wait_idle("random", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
